bitcoin_miner: RTL and testbench

- Single-engine Bitcoin proof-of-work nonce search.
- Accepts a 76-byte block header (without nonce) and a difficulty expressed as a required count of leading zero bits.
- Iterates nonce from 0 upward, computing SHA-256(SHA-256(header||nonce)), and returns the first nonce whose digest meets the target, together with that digest.
- Sits behind a valid/ready request port and a valid/ready result port.

---
 rtl/bitcoin_miner.sv | 208 ++++++++++++++++++++
 tb/tb_bitcoin_miner.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_miner.sv
// bitcoin_miner: iterative double-SHA-256 nonce search behind valid/ready ports.
// Define BITCOIN_MIDSTATE_EN to compress header block 1 once per request.
module bitcoin_miner (
    input  logic         clk,
    input  logic         rst,
    input  logic [607:0] block_header,
    input  logic [7:0]   hash_target,
    input  logic         req_val,
    output logic         req_rdy,
    output logic [31:0]  golden_nonce,
    output logic [255:0] golden_digest,
    output logic         golden_nonce_val,
    input  logic         golden_nonce_rdy
);
    typedef enum logic [2:0] {
        IDLE,
        HASH1,
        HASH2,
        CHECK,
        DONE
    } state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t       state;
    logic [607:0] hdr;
    logic [7:0]   tgt;
    logic [31:0]  nonce;
    logic [6:0]   rnd;
    logic         blk;
    logic [255:0] st;
    logic [255:0] chain;
    logic [255:0] res;
    logic [31:0]  w [16];
`ifdef BITCOIN_MIDSTATE_EN
    logic [255:0] mid;
`endif

    logic [255:0] init;
    logic [511:0] msg;
    logic [255:0] sum;
    logic [255:0] st_next;
    logic [255:0] digest;
    logic [31:0]  w_new;
    logic [31:0]  nonce_le;
    logic [5:0]   t_idx;
    logic [8:0]   sh;
    logic         hit;
    logic [31:0]  a, b, c, d, e, f, g, hh;
    logic [31:0]  s0, s1, ch, mj, t1, t2;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Chaining value and message block for the compression about to load
    always_comb begin
        nonce_le = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
        init = IV;
        msg = {res, 32'h80000000, 160'd0, 64'd256};
        if (state == HASH1) begin
            if (blk) begin
`ifdef BITCOIN_MIDSTATE_EN
                init = mid;
`else
                init = res;
`endif
                msg = {hdr[95:0], nonce_le, 32'h80000000, 288'd0, 64'd640};
            end else begin
                msg = hdr[607:96];
            end
        end
    end

    always_comb begin
        {a, b, c, d, e, f, g, hh} = st;
        t_idx = rnd[5:0] - 6'd1;
        s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
        ch = (e & f) ^ (~e & g);
        t1 = hh + s1 + ch + K[t_idx] + w[0];
        s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
        mj = (a & b) ^ (a & c) ^ (b & c);
        t2 = s0 + mj;
        st_next = {t1 + t2, a, b, c, d + t1, e, f, g};
        w_new = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10))
              + w[9]
              + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3))
              + w[0];
    end

    always_comb begin
        sum = '0;
        digest = '0;
        for (int i = 0; i < 8; i++) begin
            sum[255 - 32*i -: 32] = chain[255 - 32*i -: 32] + st[255 - 32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            digest[8*i +: 8] = res[255 - 8*i -: 8];
        end
        // Shift of 256 (target 0) leaves nothing, so it always hits
        sh = 9'd256 - {1'b0, tgt};
        hit = (digest >> sh) == 256'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            req_rdy <= 1'b1;
            golden_nonce_val <= 1'b0;
            golden_nonce <= '0;
            golden_digest <= '0;
            nonce <= '0;
            rnd <= '0;
            blk <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val && req_rdy) begin
                        hdr <= block_header;
                        tgt <= hash_target;
                        nonce <= '0;
                        rnd <= '0;
                        blk <= 1'b0;
                        req_rdy <= 1'b0;
                        state <= HASH1;
                    end
                end
                HASH1, HASH2: begin
                    if (rnd == 7'd0) begin
                        chain <= init;
                        st <= init;
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= msg[511 - 32*i -: 32];
                        end
                        rnd <= 7'd1;
                    end else if (rnd != 7'd65) begin
                        st <= st_next;
                        for (int i = 0; i < 15; i++) begin
                            w[i] <= w[i + 1];
                        end
                        w[15] <= w_new;
                        rnd <= rnd + 7'd1;
                    end else begin
                        res <= sum;
                        rnd <= 7'd0;
                        if (state == HASH2) begin
                            state <= CHECK;
                        end else if (blk) begin
                            state <= HASH2;
                        end else begin
                            blk <= 1'b1;
`ifdef BITCOIN_MIDSTATE_EN
                            mid <= sum;
`endif
                        end
                    end
                end
                CHECK: begin
                    if (hit) begin
                        golden_nonce <= nonce;
                        golden_digest <= digest;
                        golden_nonce_val <= 1'b1;
                        state <= DONE;
                    end else begin
                        nonce <= nonce + 32'd1;
`ifdef BITCOIN_MIDSTATE_EN
                        blk <= 1'b1;
`else
                        blk <= 1'b0;
`endif
                        state <= HASH1;
                    end
                end
                DONE: begin
                    if (golden_nonce_val && golden_nonce_rdy) begin
                        golden_nonce_val <= 1'b0;
                        req_rdy <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcoin_miner.sv
// tb_bitcoin_miner: random headers checked against a plain SHA-256d reference.
// Headers are chosen so the first winning nonce stays small and runs stay short.
module tb_bitcoin_miner;
    localparam int LIM = 30;

    localparam logic [31:0] IVT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [607:0] block_header = '0;
    logic [7:0]   hash_target = '0;
    logic         req_val = 1'b0;
    logic         req_rdy;
    logic [31:0]  golden_nonce;
    logic [255:0] golden_digest;
    logic         golden_nonce_val;
    logic         golden_nonce_rdy = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    bitcoin_miner dut (
        .clk(clk),
        .rst(rst),
        .block_header(block_header),
        .hash_target(hash_target),
        .req_val(req_val),
        .req_rdy(req_rdy),
        .golden_nonce(golden_nonce),
        .golden_digest(golden_digest),
        .golden_nonce_val(golden_nonce_val),
        .golden_nonce_rdy(golden_nonce_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-message SHA-256 with padding and a full 64-word schedule
    function automatic logic [255:0] sha256(input logic [7:0] m [128], input int len);
        logic [7:0]  bb [128];
        logic [31:0] hv [8];
        logic [31:0] ww [64];
        logic [31:0] v [8];
        logic [31:0] x1, x2;
        logic [63:0] bits;
        int nb;
        nb = (len + 72) / 64;
        for (int i = 0; i < 128; i++) bb[i] = (i < len) ? m[i] : 8'h00;
        bb[len] = 8'h80;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 8; i++) bb[nb*64 - 1 - i] = bits[8*i +: 8];
        for (int i = 0; i < 8; i++) hv[i] = IVT[i];
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < 16; i++) begin
                ww[i] = {bb[64*k + 4*i], bb[64*k + 4*i + 1],
                         bb[64*k + 4*i + 2], bb[64*k + 4*i + 3]};
            end
            for (int i = 16; i < 64; i++) begin
                ww[i] = (ror(ww[i-2], 17) ^ ror(ww[i-2], 19) ^ (ww[i-2] >> 10))
                      + ww[i-7]
                      + (ror(ww[i-15], 7) ^ ror(ww[i-15], 18) ^ (ww[i-15] >> 3))
                      + ww[i-16];
            end
            for (int i = 0; i < 8; i++) v[i] = hv[i];
            for (int t = 0; t < 64; t++) begin
                x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + ww[t];
                x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int j = 7; j > 0; j--) v[j] = v[j-1];
                v[4] = v[4] + x1;
                v[0] = x1 + x2;
            end
            for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
        end
        return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    endfunction

    function automatic logic [255:0] dsha(input logic [607:0] h, input logic [31:0] n);
        logic [7:0]   m [128];
        logic [255:0] h1, h2, dg;
        for (int i = 0; i < 128; i++) m[i] = 8'h00;
        for (int i = 0; i < 76; i++) m[i] = h[607 - 8*i -: 8];
        m[76] = n[7:0];
        m[77] = n[15:8];
        m[78] = n[23:16];
        m[79] = n[31:24];
        h1 = sha256(m, 80);
        for (int i = 0; i < 128; i++) m[i] = 8'h00;
        for (int i = 0; i < 32; i++) m[i] = h1[255 - 8*i -: 8];
        h2 = sha256(m, 32);
        dg = '0;
        for (int i = 0; i < 32; i++) dg[8*i +: 8] = h2[255 - 8*i -: 8];
        return dg;
    endfunction

    function automatic bit meets(input logic [255:0] dg, input logic [7:0] t);
        int lz;
        bit stop;
        lz = 0;
        stop = 1'b0;
        for (int i = 255; i >= 0; i--) begin
            if (!stop) begin
                if (dg[i]) stop = 1'b1;
                else lz++;
            end
        end
        return lz >= int'(t);
    endfunction

    function automatic int first_nonce(input logic [607:0] h, input logic [7:0] t);
        for (int n = 0; n <= LIM; n++) begin
            if (meets(dsha(h, 32'(n)), t)) return n;
        end
        return -1;
    endfunction

    function automatic logic [607:0] rand_header();
        logic [607:0] r;
        for (int i = 0; i < 19; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input logic [7:0] t, output logic [607:0] h);
        h = rand_header();
        for (int k = 0; k < 500 && first_nonce(h, t) < 0; k++) h = rand_header();
    endtask

    task automatic issue(input logic [607:0] h, input logic [7:0] t);
        int k;
        k = 0;
        while (!req_rdy && k < 20) begin
            tick();
            k++;
        end
        check("issue_rdy", 256'(req_rdy), 256'(1));
        block_header = h;
        hash_target = t;
        req_val = 1'b1;
        tick();
        req_val = 1'b0;
    endtask

    task automatic wait_val(input int budget, output bit rdy_hi);
        int c;
        c = 0;
        rdy_hi = 1'b0;
        while (!golden_nonce_val && c < budget) begin
            tick();
            c++;
            if (req_rdy) rdy_hi = 1'b1;
        end
        check("wait_val", 256'(golden_nonce_val), 256'(1));
    endtask

    task automatic consume(input string tag, input int exp);
        golden_nonce_rdy = 1'b1;
        tick();
        golden_nonce_rdy = 1'b0;
        check({tag, "_val_drop"}, 256'(golden_nonce_val), 256'(0));
        check({tag, "_rdy_back"}, 256'(req_rdy), 256'(1));
        check({tag, "_nonce_kept"}, 256'(golden_nonce), 256'(exp));
    endtask

    task automatic run_search(input logic [607:0] h, input logic [7:0] t,
                              input string tag, input bit early, output int got);
        int exp;
        bit rh;
        exp = first_nonce(h, t);
        got = -1;
        if (exp < 0) begin
            check({tag, "_pick"}, 256'(0), 256'(1));
            return;
        end
        issue(h, t);
        if (early) golden_nonce_rdy = 1'b1;
        wait_val((exp + 2) * 200 + 300, rh);
        check({tag, "_busy_rdy"}, 256'(rh), 256'(0));
        check({tag, "_nonce"}, 256'(golden_nonce), 256'(exp));
        check({tag, "_digest"}, golden_digest, dsha(h, 32'(exp)));
        check({tag, "_zeros"}, 256'(meets(golden_digest, t)), 256'(1));
        got = int'(golden_nonce);
        consume(tag, exp);
    endtask

    initial begin
        logic [607:0] h;
        logic [31:0]  cap_n;
        logic [255:0] cap_d;
        logic [7:0]   t;
        int n2, n4, n6, got, exp, nb6;
        bit rh, bad;

        tick();
        tick();
        check("rst_req_rdy", 256'(req_rdy), 256'(1));
        check("rst_val", 256'(golden_nonce_val), 256'(0));
        check("rst_nonce", 256'(golden_nonce), 256'(0));
        check("rst_digest", golden_digest, 256'(0));
        rst = 1'b0;
        tick();

        run_search('0, 8'd0, "zero_t0", 1'b0, got);

        // One header, rising targets, consumer ready before the result
        pick(8'd6, h);
        run_search(h, 8'd2, "seq_t2", 1'b1, n2);
        run_search(h, 8'd4, "seq_t4", 1'b1, n4);
        run_search(h, 8'd6, "seq_t6", 1'b1, n6);
        check("seq_monotonic", 256'(n2 <= n4 && n4 <= n6), 256'(1));

        for (int r = 0; r < 3; r++) begin
            t = 8'($urandom_range(0, 5));
            pick(t, h);
            run_search(h, t, $sformatf("rnd%0d_t%0d", r, t), 1'b0, got);
        end

        pick(8'd3, h);
        exp = first_nonce(h, 8'd3);
        issue(h, 8'd3);
        wait_val((exp + 2) * 200 + 300, rh);
        check("bp_nonce", 256'(golden_nonce), 256'(exp));
        cap_n = golden_nonce;
        cap_d = golden_digest;
        bad = 1'b0;
        repeat (50) begin
            tick();
            if (!golden_nonce_val || req_rdy) bad = 1'b1;
            if (golden_nonce !== cap_n || golden_digest !== cap_d) bad = 1'b1;
        end
        check("bp_stable", 256'(bad), 256'(0));
        consume("bp", exp);

        pick(8'd3, h);
        exp = first_nonce(h, 8'd3);
        block_header = h;
        hash_target = 8'd3;
        req_val = 1'b1;
        tick();
        bad = 1'b0;
        repeat (3) begin
            block_header = rand_header();
            hash_target = 8'($urandom);
            tick();
            if (req_rdy) bad = 1'b1;
        end
        req_val = 1'b0;
        check("hold_rdy_low", 256'(bad), 256'(0));
        wait_val((exp + 2) * 200 + 300, rh);
        check("hold_busy_rdy", 256'(rh), 256'(0));
        check("hold_nonce", 256'(golden_nonce), 256'(exp));
        check("hold_digest", golden_digest, dsha(h, 32'(exp)));
        consume("hold", exp);

        // Header whose target-6 search is still running after 1000 cycles
        h = rand_header();
        for (int k = 0; k < 500; k++) begin
            nb6 = first_nonce(h, 8'd6);
            if ((nb6 < 0 || nb6 >= 8) && first_nonce(h, 8'd4) >= 0) break;
            h = rand_header();
        end
        issue(h, 8'd6);
        bad = 1'b0;
        repeat (1000) begin
            tick();
            if (golden_nonce_val) bad = 1'b1;
        end
        check("mr_no_early", 256'(bad), 256'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_req_rdy", 256'(req_rdy), 256'(1));
        check("mr_val", 256'(golden_nonce_val), 256'(0));
        check("mr_nonce", 256'(golden_nonce), 256'(0));
        check("mr_digest", golden_digest, 256'(0));
        run_search(h, 8'd4, "mr_after", 1'b0, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
